alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller between the decoder and the 32-bit ALU: decodes ALUOp/funct,
// drives registered operands/code, captures result, flags and branch outcome.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_aluop,
  input  logic [5:0]  req_funct,
  input  logic [1:0]  req_br,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_control_code,
  input  logic [31:0] alu_result,
  input  logic        alu_v,
  input  logic        alu_n,
  input  logic        alu_z,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_v,
  output logic        rsp_n,
  output logic        rsp_z,
  output logic        rsp_taken,
  output logic        rsp_illegal,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CODE_NOP = 4'b1111;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_req_ready;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [3:0]  r_code;
  logic [1:0]  r_br;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_result;
  logic        r_rsp_v;
  logic        r_rsp_n;
  logic        r_rsp_z;
  logic        r_rsp_taken;
  logic        r_rsp_illegal;
  logic [15:0] r_op_count;

  logic [4:0]  w_dec;
  logic        w_dec_illegal;
  logic [3:0]  w_dec_code;
  logic        w_accept;
  logic        w_rsp_fire;
  logic        w_taken;

  // Returns {illegal, code}; illegal requests report the NOP code.
  function automatic logic [4:0] decode(input logic [1:0] aluop, input logic [5:0] funct);
    logic [4:0] d;
    d = {1'b1, CODE_NOP};
    case (aluop)
      2'b00: d = {1'b0, 4'b0010};
      2'b01: d = {1'b0, 4'b0110};
      2'b10: begin
        case (funct)
          6'b100000: d = {1'b0, 4'b0010};
          6'b100010: d = {1'b0, 4'b0110};
          6'b100100: d = {1'b0, 4'b0000};
          6'b100101: d = {1'b0, 4'b0001};
          6'b100111: d = {1'b0, 4'b1001};
          6'b101100: d = {1'b0, 4'b1100};
          6'b100110: d = {1'b0, 4'b1101};
          6'b101010: d = {1'b0, 4'b0111};
          default:   d = {1'b1, CODE_NOP};
        endcase
      end
      default: d = {1'b1, CODE_NOP};
    endcase
    return d;
  endfunction

  assign w_dec         = decode(req_aluop, req_funct);
  assign w_dec_illegal = w_dec[4];
  assign w_dec_code    = w_dec[3:0];
  // req_ready is only ever high in IDLE, so this implies the IDLE state.
  assign w_accept      = req_valid & r_req_ready;
  assign w_rsp_fire    = r_rsp_valid & rsp_ready;

  // Branch condition from the live ALU flags during EXEC.
  always_comb begin
    w_taken = 1'b0;
    case (r_br)
      2'b01:   w_taken = alu_z;
      2'b10:   w_taken = ~alu_z;
      2'b11:   w_taken = alu_n;
      default: w_taken = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = w_dec_illegal ? S_RESP : S_EXEC;
        else          w_next_state = S_IDLE;
      end
      S_EXEC: w_next_state = S_RESP;
      S_RESP: begin
        if (w_rsp_fire) w_next_state = S_IDLE;
        else            w_next_state = S_RESP;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, datapath capture and completion counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_req_ready   <= 1'b0;
      r_op1         <= 32'd0;
      r_op2         <= 32'd0;
      r_code        <= CODE_NOP;
      r_br          <= 2'b00;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= 32'd0;
      r_rsp_v       <= 1'b0;
      r_rsp_n       <= 1'b0;
      r_rsp_z       <= 1'b0;
      r_rsp_taken   <= 1'b0;
      r_rsp_illegal <= 1'b0;
      r_op_count    <= 16'd0;
    end else begin
      r_state     <= w_next_state;
      r_req_ready <= (w_next_state == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op1         <= req_a;
            r_op2         <= req_b;
            r_br          <= req_br;
            r_code        <= w_dec_code;
            r_rsp_valid   <= w_dec_illegal;
            r_rsp_illegal <= w_dec_illegal;
            r_rsp_result  <= 32'd0;
            r_rsp_v       <= 1'b0;
            r_rsp_n       <= 1'b0;
            r_rsp_z       <= 1'b0;
            r_rsp_taken   <= 1'b0;
          end
        end
        S_EXEC: begin
          r_rsp_result  <= alu_result;
          r_rsp_v       <= alu_v;
          r_rsp_n       <= alu_n;
          r_rsp_z       <= alu_z;
          r_rsp_taken   <= w_taken;
          r_rsp_illegal <= 1'b0;
          r_rsp_valid   <= 1'b1;
          r_code        <= CODE_NOP;
        end
        S_RESP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + 16'd1;
          end
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign req_ready        = r_req_ready;
  assign alu_op1          = r_op1;
  assign alu_op2          = r_op2;
  assign alu_control_code = r_code;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_result       = r_rsp_result;
  assign rsp_v            = r_rsp_v;
  assign rsp_n            = r_rsp_n;
  assign rsp_z            = r_rsp_z;
  assign rsp_taken        = r_rsp_taken;
  assign rsp_illegal      = r_rsp_illegal;
  assign op_count         = r_op_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU on the DUT's ALU port,
// operation-level reference model, directed plus randomized transactions.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_aluop;
  logic [5:0]  req_funct;
  logic [1:0]  req_br;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_control_code;
  logic [31:0] alu_result;
  logic        alu_v;
  logic        alu_n;
  logic        alu_z;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_v;
  logic        rsp_n;
  logic        rsp_z;
  logic        rsp_taken;
  logic        rsp_illegal;
  logic [15:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct(req_funct), .req_br(req_br),
    .req_a(req_a), .req_b(req_b),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_control_code(alu_control_code),
    .alu_result(alu_result), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_v(rsp_v), .rsp_n(rsp_n), .rsp_z(rsp_z),
    .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal), .op_count(op_count)
  );

  // Combinational ALU seen by the controller.
  always_comb begin
    alu_result = 32'd0;
    alu_v      = 1'b0;
    case (alu_control_code)
      4'b0000: alu_result = alu_op1 & alu_op2;
      4'b0001: alu_result = alu_op1 | alu_op2;
      4'b0010: begin
        alu_result = alu_op1 + alu_op2;
        alu_v = (alu_op1[31] == alu_op2[31]) && (alu_result[31] != alu_op1[31]);
      end
      4'b0110: begin
        alu_result = alu_op1 - alu_op2;
        alu_v = (alu_op1[31] != alu_op2[31]) && (alu_result[31] != alu_op1[31]);
      end
      4'b0111: alu_result = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
      4'b1001: alu_result = ~(alu_op1 | alu_op2);
      4'b1100: alu_result = alu_op1 << alu_op2[4:0];
      4'b1101: alu_result = alu_op1 ^ alu_op2;
      default: alu_result = 32'd0;
    endcase
    alu_z = (alu_result == 32'd0);
    alu_n = alu_result[31];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        legal;
    logic [3:0]  code;
    logic [31:0] res;
    logic        v, n, z, taken;
  } exp_t;

  // Operation-level reference: what each request means, computed with plain arithmetic.
  function automatic exp_t model(input logic [1:0] aluop, input logic [5:0] funct,
                                 input logic [1:0] br, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    string  op;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    op = "ILL";
    if (aluop == 2'b00) op = "ADD";
    else if (aluop == 2'b01) op = "SUB";
    else if (aluop == 2'b10) begin
      case (funct)
        6'b100000: op = "ADD";
        6'b100010: op = "SUB";
        6'b100100: op = "AND";
        6'b100101: op = "OR";
        6'b100111: op = "NOR";
        6'b101100: op = "SLL";
        6'b100110: op = "XOR";
        6'b101010: op = "SLT";
        default:   op = "ILL";
      endcase
    end
    e.legal = (op != "ILL");
    e.v = 1'b0;
    e.res = 32'd0;
    e.code = 4'b1111;
    case (op)
      "ADD": begin s = sa + sb; e.res = a + b; e.code = 4'b0010;
                   e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      "SUB": begin s = sa - sb; e.res = a - b; e.code = 4'b0110;
                   e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      "AND": begin e.res = a & b;       e.code = 4'b0000; end
      "OR":  begin e.res = a | b;       e.code = 4'b0001; end
      "NOR": begin e.res = ~(a | b);    e.code = 4'b1001; end
      "SLL": begin e.res = a << b[4:0]; e.code = 4'b1100; end
      "XOR": begin e.res = a ^ b;       e.code = 4'b1101; end
      "SLT": begin e.res = (sa < sb) ? 32'd1 : 32'd0; e.code = 4'b0111; end
      default: ;
    endcase
    e.z = e.legal && (e.res == 32'd0);
    e.n = e.legal && e.res[31];
    case (br)
      2'b01:   e.taken = e.legal && e.z;
      2'b10:   e.taken = e.legal && !e.z;
      2'b11:   e.taken = e.legal && e.n;
      default: e.taken = 1'b0;
    endcase
    return e;
  endfunction

  // One full transaction, entered and left at a falling edge.
  task automatic do_op(input logic [1:0] aluop, input logic [5:0] funct, input logic [1:0] br,
                       input logic [31:0] a, input logic [31:0] b, input int hold, input bit keep);
    exp_t e;
    int   waited;
    e = model(aluop, funct, br, a, b);
    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    req_aluop = aluop; req_funct = funct; req_br = br; req_a = a; req_b = b;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
    if (e.legal) begin
      chk("exec_code", alu_control_code, e.code);
      chk("exec_op1", alu_op1, a);
      chk("exec_op2", alu_op2, b);
      chk("exec_valid", rsp_valid, 1'b0);
      chk("exec_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_result", rsp_result, e.res);
    chk("rsp_flags", {rsp_v, rsp_n, rsp_z}, {e.v, e.n, e.z});
    chk("rsp_taken", rsp_taken, e.taken);
    chk("rsp_illegal", rsp_illegal, !e.legal);
    chk("rsp_code_nop", alu_control_code, 4'b1111);
    chk("rsp_ready_low", req_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_result", rsp_result, e.res);
      chk("bp_taken", rsp_taken, e.taken);
      chk("bp_req_ready", req_ready, 1'b0);
      chk("bp_count", op_count, exp_count[15:0]);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % 65536;
    chk("done_count", op_count, exp_count[15:0]);
    chk("done_valid", rsp_valid, 1'b0);
    chk("done_req_ready", req_ready, 1'b1);
  endtask

  logic [5:0] funct_tab [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b100111, 6'b101100, 6'b100110, 6'b101010};

  initial begin
    logic [31:0] ra, rb;
    logic [5:0]  rf;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_aluop = 2'b00; req_funct = 6'd0; req_br = 2'b00; req_a = 32'd0; req_b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_op1", alu_op1, 32'd0);
    chk("rst_op2", alu_op2, 32'd0);
    chk("rst_code", alu_control_code, 4'b1111);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp", {rsp_result, rsp_v, rsp_n, rsp_z, rsp_taken, rsp_illegal}, 37'd0);
    chk("rst_count", op_count, 16'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1'b1);

    do_op(2'b10, 6'b100000, 2'b00, 32'd5, 32'd7, 0, 1'b0);
    do_op(2'b01, 6'b000000, 2'b01, 32'h1234, 32'h1234, 0, 1'b0);
    do_op(2'b01, 6'b000000, 2'b10, 32'h1234, 32'h1234, 0, 1'b0);
    do_op(2'b10, 6'b101010, 2'b11, 32'hFFFFFFFF, 32'd1, 0, 1'b0);
    do_op(2'b01, 6'b000000, 2'b11, 32'd3, 32'd9, 0, 1'b0);
    do_op(2'b10, 6'b000000, 2'b01, 32'd8, 32'd8, 0, 1'b0);
    do_op(2'b11, 6'b100000, 2'b00, 32'd1, 32'd2, 1, 1'b0);
    do_op(2'b00, 6'b000000, 2'b00, 32'h7FFFFFFF, 32'd1, 5, 1'b1);
    do_op(2'b10, 6'b100100, 2'b10, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rf = ($urandom_range(0, 3) == 0) ? 6'($urandom) : funct_tab[$urandom_range(0, 7)];
      do_op(2'($urandom_range(0, 3)), rf, 2'($urandom_range(0, 3)), ra, rb,
            int'($urandom_range(0, 3)), (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    // Reset while EXEC is in flight drops the op.
    req_aluop = 2'b10; req_funct = 6'b100101; req_br = 2'b00; req_a = 32'd3; req_b = 32'd4;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_exec_code", alu_control_code, 4'b0001);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", rsp_valid, 1'b0);
    chk("midrst_code", alu_control_code, 4'b1111);
    chk("midrst_count", op_count, 16'd0);
    chk("midrst_req_ready", req_ready, 1'b0);
    reset = 1'b0;
    exp_count = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready_after", req_ready, 1'b1);
    chk("midrst_valid_after", rsp_valid, 1'b0);

    // Counter wrap: preload the completion count to its maximum.
    force dut.r_op_count = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.r_op_count;
    exp_count = 16'hFFFF;
    do_op(2'b00, 6'b000000, 2'b00, 32'd1, 32'd1, 0, 1'b0);
    chk("wrap_zero", op_count, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
